sm_arbiter: RTL and testbench
=============================

SM_ARBITER -- requirements
Module: sm_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 63, giving the maximum number of WAIT cycles before the operation aborts (range 8..255).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_b  input  1  synchronous, active-high reset (1 = reset, sampled on the clk rising edge).
REQ-004 The block SHALL have ports req0, req1  input  1 each  requester operation request.
REQ-005 The block SHALL have ports x0, y0, x1, y1  input  8 each  sign-magnitude operands per requester (bit 7 = sign).
REQ-006 The block SHALL have ports gnt0, gnt1  output  1 each  requester currently owns the multiplier.
REQ-007 The block SHALL have ports done0, done1  output  1 each  one-cycle completion pulse.
REQ-008 The block SHALL have ports res0, res1  output  16 each  product, held until the same requester's next done.
REQ-009 The block SHALL have ports err0, err1  output  1 each  last operation timed out; valid with done, held until the next done.
REQ-010 The block SHALL have port m_bgn  output  1  start strobe to the sign-magnitude multiplier.
REQ-011 The block SHALL have port m_ibus  output  8  operand bus to the multiplier.
REQ-012 The block SHALL have port m_obus  input  8  result bus from the multiplier.
REQ-013 The block SHALL have port m_fin  input  1  multiplier finished.

Function
REQ-014 FSM states SHALL be IDLE, START, OPX, OPY, WAIT and DONE; every state lasts exactly one cycle except IDLE and WAIT.
REQ-015 IDLE: if any req is high, the arbiter SHALL grant, latch that requester's x and y into internal registers, and go to START.
REQ-016 Arbitration SHALL be round-robin: pointer reset value 0; with both req high, the pointer's requester wins; after each DONE the pointer moves to the other requester.
REQ-017 With a single req high, that requester SHALL be granted regardless of the pointer.
REQ-018 START SHALL drive m_bgn=1 and m_ibus=0.
REQ-019 OPX SHALL drive m_ibus = latched x; OPY SHALL drive m_ibus = latched y; m_bgn=0 in both.
REQ-020 m_bgn SHALL be 0 and m_ibus SHALL be 0 in every state except START, OPX and OPY.
REQ-021 WAIT SHALL shift m_obus into a 2-byte capture register every cycle (hi <= lo, lo <= m_obus).
REQ-022 WAIT SHALL count cycles with an 8-bit counter cleared on entry to WAIT.
REQ-023 When m_fin=1 in WAIT, the FSM SHALL go to DONE with result {hi, lo}: the two m_obus bytes sampled in the two cycles before m_fin, earlier byte in the high half.
REQ-024 If the WAIT counter reaches TIMEOUT with m_fin still 0, the FSM SHALL go to DONE with result 0x0000 and err=1.
REQ-025 m_fin and the timeout occurring in the same cycle SHALL resolve as a normal completion with err=0.
REQ-026 m_fin seen in any state other than WAIT SHALL be ignored.
REQ-027 DONE SHALL pulse the granted requester's done, update its res and err, and return to IDLE.
REQ-028 Total latency from the IDLE grant cycle SHALL be 4 cycles plus the number of WAIT cycles.
REQ-029 gnt SHALL be high for the granted requester from START through DONE inclusive; at most one gnt is high at any time.
REQ-030 req deasserting after grant SHALL NOT abort the operation; done and res are still delivered.
REQ-031 req still high in the cycle after DONE SHALL be eligible for grant in the normal way; IDLE always lasts at least one cycle between operations.
REQ-032 x and y changing after the grant cycle SHALL NOT affect the operation in progress.
REQ-033 The other requester's res and err SHALL be unchanged by any operation.

Reset
REQ-034 rst_b=1 SHALL force IDLE, pointer=0, the WAIT counter and capture register cleared, and all outputs 0 (gnt, done, res, err, m_bgn, m_ibus) from the next edge, in any state including mid-operation.
REQ-035 An operation interrupted by reset SHALL produce no done pulse; a req high after reset is released SHALL be granted anew.

Verification
REQ-036 The bench SHALL cover a single operation: req0, x0=0x97, y0=0x83; a multiplier model that emits m_obus 0x00 then 0x45 and then m_fin -> m_bgn=1 for one cycle, m_ibus sequence 0x00, 0x97, 0x83; done0 pulse; res0=0x0045; err0=0.
REQ-037 The bench SHALL cover simultaneous requests: req0 and req1 high together after reset -> req0 served first, then req1; repeating the simultaneous requests again serves req0 then req1; gnt signals never overlap.
REQ-038 The bench SHALL cover a timeout: the model never asserts m_fin, TIMEOUT=63 -> done0 after 63 WAIT cycles with res0=0x0000 and err0=1; the next normal operation clears err0.
REQ-039 The bench SHALL cover reset mid-WAIT: rst_b=1 for one cycle -> all outputs 0 next cycle; no done; a new req1 then completes normally.
REQ-040 The bench SHALL cover a request dropped mid-operation: req1 drops during WAIT and x1 changes -> done1 still pulses and res1 reflects the operand latched at grant.
REQ-041 The bench SHALL cover the tie and the late fin: m_fin arrives on the timeout cycle -> err=0 with the captured result; an m_fin pulse in IDLE changes no output.

Source files
------------

// File: rtl/sm_arbiter.sv
// Round-robin arbiter sharing one byte-serial sign-magnitude multiplier between two requesters.
// Each operation: grant, strobe + operands, wait for the result (or time out), report it.
module sm_arbiter #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        err0,
    output logic        err1,
    output logic        m_bgn,
    output logic [7:0]  m_ibus,
    input  logic [7:0]  m_obus,
    input  logic        m_fin
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OPX,
        ST_OPY,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic              ptr_q;
    logic              owner_q;
    logic [7:0]        opx_q;
    logic [7:0]        opy_q;
    logic [7:0]        cap_hi_q;
    logic [7:0]        cap_lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              done0_q;
    logic              done1_q;
    logic [15:0]       res0_q;
    logic [15:0]       res1_q;
    logic              err0_q;
    logic              err1_q;
    logic              m_bgn_q;
    logic [7:0]        m_ibus_q;

    logic              pick1_c;
    logic              last_wait_c;

    // Requester 1 wins when it is alone or when the pointer favours it.
    always_comb begin
        pick1_c     = req1 & (~req0 | ptr_q);
        last_wait_c = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            opx_q    <= 8'h00;
            opy_q    <= 8'h00;
            cap_hi_q <= 8'h00;
            cap_lo_q <= 8'h00;
            cnt_q    <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            res0_q   <= 16'h0000;
            res1_q   <= 16'h0000;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            m_bgn_q  <= 1'b0;
            m_ibus_q <= 8'h00;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_q  <= pick1_c;
                        opx_q    <= pick1_c ? x1 : x0;
                        opy_q    <= pick1_c ? y1 : y0;
                        gnt0_q   <= ~pick1_c;
                        gnt1_q   <= pick1_c;
                        m_bgn_q  <= 1'b1;
                        m_ibus_q <= 8'h00;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    m_bgn_q  <= 1'b0;
                    m_ibus_q <= opx_q;
                    state_q  <= ST_OPX;
                end
                ST_OPX: begin
                    m_ibus_q <= opy_q;
                    state_q  <= ST_OPY;
                end
                ST_OPY: begin
                    m_ibus_q <= 8'h00;
                    cnt_q    <= '0;
                    cap_hi_q <= 8'h00;
                    cap_lo_q <= 8'h00;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Result is the two bytes captured before the cycle m_fin is seen.
                    cap_hi_q <= cap_lo_q;
                    cap_lo_q <= m_obus;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (m_fin || last_wait_c) begin
                        state_q <= ST_DONE;
                        if (owner_q) begin
                            done1_q <= 1'b1;
                            res1_q  <= m_fin ? {cap_hi_q, cap_lo_q} : 16'h0000;
                            err1_q  <= ~m_fin;
                        end else begin
                            done0_q <= 1'b1;
                            res0_q  <= m_fin ? {cap_hi_q, cap_lo_q} : 16'h0000;
                            err0_q  <= ~m_fin;
                        end
                    end
                end
                ST_DONE: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    ptr_q   <= ~owner_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign res0   = res0_q;
    assign res1   = res1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign m_bgn  = m_bgn_q;
    assign m_ibus = m_ibus_q;

endmodule

// File: tb/tb_sm_arbiter.sv
// Bench for sm_arbiter: transaction-level model (winner, latency, result) checked every cycle.
module tb_sm_arbiter;

    localparam int unsigned TIMEOUT = 63;

    logic        clk;
    logic        rst_b;
    logic        req0, req1;
    logic [7:0]  x0, y0, x1, y1;
    logic        gnt0, gnt1, done0, done1, err0, err1, m_bgn, m_fin;
    logic [15:0] res0, res1;
    logic [7:0]  m_ibus, m_obus;

    int          checks = 0;
    int          errors = 0;

    // Model state: per-requester held result/error, round-robin pointer.
    logic [15:0] mres [2];
    logic        merr [2];
    int          ptr;

    sm_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .err0(err0), .err1(err1),
        .m_bgn(m_bgn), .m_ibus(m_ibus),
        .m_obus(m_obus), .m_fin(m_fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, ".res0"}, res0, mres[0]);
        check({tag, ".res1"}, res1, mres[1]);
        check({tag, ".err0"}, 16'(err0), 16'(merr[0]));
        check({tag, ".err1"}, 16'(err1), 16'(merr[1]));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".gnt0"}, 16'(gnt0), 16'h0);
        check({tag, ".gnt1"}, 16'(gnt1), 16'h0);
        check({tag, ".done0"}, 16'(done0), 16'h0);
        check({tag, ".done1"}, 16'(done1), 16'h0);
        check({tag, ".m_bgn"}, 16'(m_bgn), 16'h0);
        check({tag, ".m_ibus"}, 16'(m_ibus), 16'h0);
        check_held(tag);
    endtask

    task automatic model_clear();
        mres[0] = 16'h0; mres[1] = 16'h0;
        merr[0] = 1'b0;  merr[1] = 1'b0;
        ptr = 0;
    endtask

    task automatic randomize_operands();
        x0 = 8'($urandom); y0 = 8'($urandom);
        x1 = 8'($urandom); y1 = 8'($urandom);
    endtask

    task automatic do_reset(input string tag);
        rst_b = 1'b1; req0 = 1'b0; req1 = 1'b0; m_fin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        check_quiet({tag, ".in_reset"});
        rst_b = 1'b0;
        @(negedge clk);
        check_quiet({tag, ".after_reset"});
    endtask

    // One operation. fin_at = WAIT cycle index carrying m_fin (<0: never).
    // Called at a negedge with the DUT idle; returns at the idle negedge after DONE.
    task automatic run_op(input string name, input logic r0, input logic r1,
                          input logic [7:0] xa, input logic [7:0] ya, input int fin_at,
                          input logic [7:0] hb, input logic [7:0] lb, input bit drop);
        int    win, w, last, k;
        bit    normal;
        string tag;
        win    = (r0 && r1) ? ptr : (r1 ? 1 : 0);
        normal = (fin_at >= 0) && (fin_at < int'(TIMEOUT));
        w      = normal ? fin_at + 1 : int'(TIMEOUT);
        last   = 4 + w;
        randomize_operands();
        if (win == 0) begin x0 = xa; y0 = ya; end
        else begin x1 = xa; y1 = ya; end
        req0 = r0; req1 = r1;
        m_fin = 1'($urandom); m_obus = 8'($urandom);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            tag = $sformatf("%s.c%0d", name, c);
            check({tag, ".gnt_overlap"}, 16'(gnt0 & gnt1), 16'h0);
            check({tag, ".gnt0"}, 16'(gnt0), 16'(c <= last && win == 0));
            check({tag, ".gnt1"}, 16'(gnt1), 16'(c <= last && win == 1));
            check({tag, ".m_bgn"}, 16'(m_bgn), 16'(c == 1));
            check({tag, ".m_ibus"}, 16'(m_ibus),
                  (c == 2) ? 16'(xa) : (c == 3) ? 16'(ya) : 16'h0);
            check({tag, ".done0"}, 16'(done0), 16'(c == last && win == 0));
            check({tag, ".done1"}, 16'(done1), 16'(c == last && win == 1));
            if (c == last) begin
                mres[win] = normal ? {hb, lb} : 16'h0000;
                merr[win] = !normal;
                ptr       = 1 - win;
            end
            check_held(tag);
            // Inputs for the next edge; operands keep changing after the grant.
            randomize_operands();
            if (drop && c == 5) begin
                if (win == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            k = c - 4;
            if (c < 4 || c == last) begin
                m_fin  = 1'($urandom);
                m_obus = 8'($urandom);
            end else if (c < last) begin
                m_fin  = (k == fin_at);
                m_obus = (k == fin_at - 2) ? hb : (k == fin_at - 1) ? lb : 8'($urandom);
            end else begin
                m_fin = 1'b0;
                req0  = 1'b0;
                req1  = 1'b0;
            end
        end
    endtask

    initial begin
        int r;
        rst_b = 1'b1; req0 = 1'b0; req1 = 1'b0; m_fin = 1'b0; m_obus = 8'h00;
        x0 = 8'h00; y0 = 8'h00; x1 = 8'h00; y1 = 8'h00;
        model_clear();

        do_reset("por");

        // Single operation with the reference bytes 0x00, 0x45.
        run_op("single", 1'b1, 1'b0, 8'h97, 8'h83, 2, 8'h00, 8'h45, 1'b0);

        // Simultaneous requests from a fresh reset alternate 0,1,0,1.
        do_reset("rr_reset");
        run_op("both_a", 1'b1, 1'b1, 8'h12, 8'h34, 3, 8'hA5, 8'h5A, 1'b0);
        run_op("both_b", 1'b1, 1'b1, 8'h56, 8'h78, 4, 8'h3C, 8'hC3, 1'b0);
        run_op("both_c", 1'b1, 1'b1, 8'h9A, 8'hBC, 2, 8'h01, 8'h02, 1'b0);
        run_op("both_d", 1'b1, 1'b1, 8'hDE, 8'hF0, 5, 8'hFE, 8'hDC, 1'b0);

        // Timeout, then a normal op clears the error flag.
        run_op("timeout", 1'b1, 1'b0, 8'h11, 8'h22, -1, 8'h00, 8'h00, 1'b0);
        run_op("after_to", 1'b1, 1'b0, 8'h33, 8'h44, 6, 8'h7E, 8'h81, 1'b0);

        // Reset during WAIT: everything clears, no done, then req1 completes.
        req0 = 1'b1; randomize_operands(); m_fin = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            randomize_operands();
            m_obus = 8'($urandom);
        end
        check("mid_reset.gnt0_before", 16'(gnt0), 16'h1);
        rst_b = 1'b1;
        @(negedge clk);
        model_clear();
        check_quiet("mid_reset.next");
        rst_b = 1'b0; req0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_quiet($sformatf("mid_reset.idle%0d", c));
        end
        run_op("post_reset", 1'b0, 1'b1, 8'h66, 8'h77, 3, 8'hBE, 8'hEF, 1'b0);

        // Request dropped in WAIT with operands changing.
        run_op("drop", 1'b0, 1'b1, 8'hC8, 8'h29, 7, 8'h12, 8'hEE, 1'b1);

        // m_fin on the last WAIT cycle wins over the timeout.
        run_op("tie", 1'b1, 1'b0, 8'h0F, 8'hF0, int'(TIMEOUT) - 1, 8'h4B, 8'hB4, 1'b0);

        // m_fin pulse while idle changes nothing.
        m_fin = 1'b1; m_obus = 8'hFF;
        @(negedge clk);
        check_quiet("idle_fin");
        m_fin = 1'b0;
        @(negedge clk);
        check_quiet("idle_fin_after");

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(1, 3));
            run_op($sformatf("rand%0d", i), r[0], r[1], 8'($urandom), 8'($urandom),
                   int'($urandom_range(2, TIMEOUT + 3)), 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                check_quiet($sformatf("rand%0d.gap", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
